// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response bus between a requester and the dmem_hs data memory.
// Carries the request channel, the response channel and the access statistics.
interface dmem_hs_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [15:0]           rd_count;
  logic [15:0]           wr_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rd_count, wr_count
  );
endinterface

// File: rtl/dmem_hs.sv
// dmem_hs: single-port data memory with a valid/ready request/response handshake.
// One access at a time: IDLE accepts, WAIT models the access latency, RESP holds
// the result until the consumer takes it. Misaligned or out-of-range addresses
// are rejected without touching memory.
// Optional feature: define DMEM_HS_STATS_EN to get saturating load/store
// counters on rd_count/wr_count; otherwise both are tied to zero.
module dmem_hs #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  dmem_hs_if.slave  bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  // Byte size of the whole array; addresses at or above it are rejected.
  localparam logic [32:0] LIMIT    = 33'(DEPTH * BYTES);
  // Low address bits that must be zero for a word-aligned access.
  localparam logic [31:0] OFF_MASK = 32'(BYTES - 1);
  // The counter holds the remaining WAIT edges before the access edge, so the
  // response appears LATENCY+1 edges after the accept edge.
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic                misaligned;
  logic                out_of_range;
  logic                acc_err;
  logic                access;
  logic                mem_wr;

  // Address decode works on the captured request, so inputs may change freely
  // while an access is in flight.
  assign idx          = addr_q[OFF_W +: IDX_W];
  assign misaligned   = (addr_q & OFF_MASK) != 32'd0;
  assign out_of_range = {1'b0, addr_q} >= LIMIT;
  assign acc_err      = misaligned | out_of_range;
  assign access       = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_wr       = access && we_q && !acc_err;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state logic: capture in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          err_d   = acc_err;
          rdata_d = (we_q || acc_err) ? '0 : mem[idx];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is never reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) begin
          mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

`ifdef DMEM_HS_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Count successful loads and stores at the access edge, sticking at all-ones.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (access && !acc_err) begin
      if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  // Statistics registers clear with the rest of the control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`else
  assign bus.rd_count = 16'd0;
  assign bus.wr_count = 16'd0;
`endif

endmodule
